// File: rtl/keypad_scan_ctrl.sv
// keypad_scan_ctrl: 4x4 matrix keypad row scanner with column synchronizer,
// press/release debounce and a two-digit key history for the display mux.
module keypad_scan_ctrl #(
  parameter int unsigned SCAN_DIV        = 4096,
  parameter int unsigned DEBOUNCE_CYCLES = 65536
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] col,
  output logic [3:0] row,
  output logic       key_valid,
  output logic [3:0] key_code,
  output logic [3:0] digit_new,
  output logic [3:0] digit_old,
  output logic       busy
);

  localparam int unsigned DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned BW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [BW-1:0] DEB_LAST   = BW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2,
    RELEASE  = 2'd3
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [3:0]    r_col_m;
  logic [3:0]    r_col_s;
  logic [DW-1:0] r_dwell;
  logic [DW-1:0] w_dwell_nxt;
  logic [BW-1:0] r_deb;
  logic [BW-1:0] w_deb_nxt;
  logic [3:0]    r_cap;
  logic [3:0]    w_cap_nxt;
  logic [3:0]    r_row;
  logic [3:0]    w_row_nxt;
  logic          r_key_valid;
  logic          w_key_valid_nxt;
  logic [3:0]    r_key_code;
  logic [3:0]    w_key_code_nxt;
  logic [3:0]    r_digit_new;
  logic [3:0]    w_digit_new_nxt;
  logic [3:0]    r_digit_old;
  logic [3:0]    w_digit_old_nxt;
  logic          r_busy;
  logic          w_col_onehot;
  logic [3:0]    w_row_rot;
  logic [3:0]    w_key;

  // Hex value of the key at the crossing of a driven row and a sensed column.
  function automatic logic [3:0] map_key(input logic [3:0] rw, input logic [3:0] cl);
    logic [3:0] k;
    k = 4'h0;
    case ({rw, cl})
      8'b0001_0001: k = 4'h1;
      8'b0001_0010: k = 4'h2;
      8'b0001_0100: k = 4'h3;
      8'b0001_1000: k = 4'hA;
      8'b0010_0001: k = 4'h4;
      8'b0010_0010: k = 4'h5;
      8'b0010_0100: k = 4'h6;
      8'b0010_1000: k = 4'hB;
      8'b0100_0001: k = 4'h7;
      8'b0100_0010: k = 4'h8;
      8'b0100_0100: k = 4'h9;
      8'b0100_1000: k = 4'hC;
      8'b1000_0001: k = 4'hF;
      8'b1000_0010: k = 4'h0;
      8'b1000_0100: k = 4'hE;
      8'b1000_1000: k = 4'hD;
      default:      k = 4'h0;
    endcase
    return k;
  endfunction

  assign w_col_onehot = (r_col_s != 4'd0) && ((r_col_s & (r_col_s - 4'd1)) == 4'd0);
  assign w_row_rot    = {r_row[2:0], r_row[3]};
  assign w_key        = map_key(r_row, r_cap);

  // Two-flop synchronizer for the asynchronous column inputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_col_m <= 4'd0;
      r_col_s <= 4'd0;
    end else begin
      r_col_m <= col;
      r_col_s <= r_col_m;
    end
  end

  // State, counters, row drive and key history registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= SCAN;
      r_dwell     <= '0;
      r_deb       <= '0;
      r_cap       <= 4'd0;
      r_row       <= 4'b0001;
      r_key_valid <= 1'b0;
      r_key_code  <= 4'd0;
      r_digit_new <= 4'd0;
      r_digit_old <= 4'd0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_dwell     <= w_dwell_nxt;
      r_deb       <= w_deb_nxt;
      r_cap       <= w_cap_nxt;
      r_row       <= w_row_nxt;
      r_key_valid <= w_key_valid_nxt;
      r_key_code  <= w_key_code_nxt;
      r_digit_new <= w_digit_new_nxt;
      r_digit_old <= w_digit_old_nxt;
      r_busy      <= (w_state_nxt != SCAN);
    end
  end

  // Next-state and datapath updates for scan, debounce, hold and release.
  always_comb begin
    w_state_nxt     = r_state;
    w_dwell_nxt     = r_dwell;
    w_deb_nxt       = r_deb;
    w_cap_nxt       = r_cap;
    w_row_nxt       = r_row;
    w_key_valid_nxt = 1'b0;
    w_key_code_nxt  = r_key_code;
    w_digit_new_nxt = r_digit_new;
    w_digit_old_nxt = r_digit_old;
    unique case (r_state)
      SCAN: begin
        if (r_dwell == DWELL_LAST) begin
          w_dwell_nxt = '0;
          if (w_col_onehot) begin
            w_cap_nxt   = r_col_s;
            w_deb_nxt   = '0;
            w_state_nxt = DEBOUNCE;
          end else begin
            w_row_nxt = w_row_rot;
          end
        end else begin
          w_dwell_nxt = r_dwell + DW'(1);
        end
      end
      DEBOUNCE: begin
        if (r_col_s != r_cap) begin
          w_deb_nxt   = '0;
          w_dwell_nxt = '0;
          w_row_nxt   = w_row_rot;
          w_state_nxt = SCAN;
        end else if (r_deb == DEB_LAST) begin
          w_deb_nxt       = '0;
          w_key_valid_nxt = 1'b1;
          w_key_code_nxt  = w_key;
          w_digit_old_nxt = r_digit_new;
          w_digit_new_nxt = w_key;
          w_state_nxt     = HELD;
        end else begin
          w_deb_nxt = r_deb + BW'(1);
        end
      end
      HELD: begin
        if (r_col_s == 4'd0) begin
          w_deb_nxt   = '0;
          w_state_nxt = RELEASE;
        end
      end
      RELEASE: begin
        if (r_col_s != 4'd0) begin
          w_deb_nxt   = '0;
          w_state_nxt = HELD;
        end else if (r_deb == DEB_LAST) begin
          w_deb_nxt   = '0;
          w_dwell_nxt = '0;
          w_row_nxt   = w_row_rot;
          w_state_nxt = SCAN;
        end else begin
          w_deb_nxt = r_deb + BW'(1);
        end
      end
      default: w_state_nxt = SCAN;
    endcase
  end

  assign row       = r_row;
  assign key_valid = r_key_valid;
  assign key_code  = r_key_code;
  assign digit_new = r_digit_new;
  assign digit_old = r_digit_old;
  assign busy      = r_busy;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// tb_keypad_scan_ctrl: directed bench with a behavioural keypad model
// (column follows the driven row of the pressed key) plus raw column forcing.
module tb_keypad_scan_ctrl;

  logic       clk;
  logic       reset;
  wire  [3:0] col;
  logic [3:0] row;
  logic       key_valid;
  logic [3:0] key_code;
  logic [3:0] digit_new;
  logic [3:0] digit_old;
  logic       busy;

  logic       press;
  logic [3:0] key_row;
  logic [3:0] key_col;
  logic       force_en;
  logic [3:0] force_val;

  int n_checks;
  int n_fail;
  int pulses;
  int consec;
  logic prev_kv;

  assign col = force_en ? force_val : ((press && (row == key_row)) ? key_col : 4'b0000);

  keypad_scan_ctrl #(.SCAN_DIV(4), .DEBOUNCE_CYCLES(8)) u_dut (
    .clk       (clk),
    .reset     (reset),
    .col       (col),
    .row       (row),
    .key_valid (key_valid),
    .key_code  (key_code),
    .digit_new (digit_new),
    .digit_old (digit_old),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse bookkeeping, sampled on the inactive edge.
  always @(negedge clk) begin
    if (key_valid) pulses++;
    if (key_valid && prev_kv) consec++;
    prev_kv = key_valid;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_pulse(input string tag, input int budget);
    bit got;
    got = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (key_valid) begin
        got = 1'b1;
        break;
      end
    end
    chk(tag, 32'(got), 32'd1);
  endtask

  task automatic wait_busy(input string tag, input logic lvl, input int budget);
    bit got;
    got = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (busy == lvl) begin
        got = 1'b1;
        break;
      end
    end
    chk(tag, 32'(got), 32'd1);
  endtask

  task automatic press_key(input logic [3:0] r, input logic [3:0] c);
    key_row = r;
    key_col = c;
    press   = 1'b1;
  endtask

  initial begin
    int snap;
    logic [3:0] mask;
    logic any_busy;
    n_checks = 0; n_fail = 0; pulses = 0; consec = 0; prev_kv = 1'b0;
    reset = 1'b1; press = 1'b0; key_row = 4'd0; key_col = 4'd0;
    force_en = 1'b0; force_val = 4'd0;

    // Reset and idle scan rotation
    tick(); tick(); tick();
    chk("rst_row", 32'(row), 32'h1);
    chk("rst_kv", 32'(key_valid), 32'd0);
    chk("rst_code", 32'(key_code), 32'd0);
    chk("rst_dnew", 32'(digit_new), 32'd0);
    chk("rst_dold", 32'(digit_old), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    any_busy = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      logic [3:0] exp_row;
      tick();
      exp_row = 4'(4'b0001 << ((i / 4) % 4));
      chk($sformatf("scan_row_%0d", i), 32'(row), 32'(exp_row));
      any_busy = any_busy | busy;
    end
    chk("idle_busy", 32'(any_busy), 32'd0);
    chk("idle_pulses", 32'(pulses), 32'd0);

    // Key 8: row 0100, col 0010, held steadily
    press_key(4'b0100, 4'b0010);
    wait_pulse("pulse_8", 200);
    chk("code_8", 32'(key_code), 32'h8);
    chk("dnew_8", 32'(digit_new), 32'h8);
    chk("dold_8", 32'(digit_old), 32'h0);
    chk("row_frozen_8", 32'(row), 32'h4);
    chk("busy_8", 32'(busy), 32'd1);
    tick();
    chk("kv_single", 32'(key_valid), 32'd0);
    for (int i = 0; i < 30; i++) tick();
    chk("row_hold_8", 32'(row), 32'h4);
    chk("one_pulse_8", 32'(pulses), 32'd1);
    press = 1'b0;
    wait_busy("idle_after_8", 1'b0, 100);
    chk("row_adv_8", 32'(row), 32'h8);

    // Key 5 then key D
    press_key(4'b0010, 4'b0010);
    wait_pulse("pulse_5", 200);
    chk("code_5", 32'(key_code), 32'h5);
    chk("dnew_5", 32'(digit_new), 32'h5);
    chk("dold_5", 32'(digit_old), 32'h8);
    for (int i = 0; i < 5; i++) tick();
    press = 1'b0;
    wait_busy("idle_after_5", 1'b0, 100);
    press_key(4'b1000, 4'b1000);
    wait_pulse("pulse_d", 200);
    chk("code_d", 32'(key_code), 32'hD);
    chk("dnew_d", 32'(digit_new), 32'hD);
    chk("dold_d", 32'(digit_old), 32'h5);
    for (int i = 0; i < 5; i++) tick();
    press = 1'b0;
    wait_busy("idle_after_d", 1'b0, 100);
    chk("pulses_3", 32'(pulses), 32'd3);

    // Bouncing press: raw column toggles every 3 cycles
    snap = pulses;
    mask = 4'd0;
    force_en = 1'b1;
    for (int k = 0; k < 30; k++) begin
      force_val = (((k / 3) % 2) == 0) ? 4'b0001 : 4'b0000;
      tick();
      mask = mask | row;
    end
    force_en = 1'b0;
    wait_busy("idle_after_bounce", 1'b0, 50);
    chk("bounce_no_pulse", 32'(pulses - snap), 32'd0);
    chk("bounce_scan_moves", 32'($countones(mask) >= 2), 32'd1);
    chk("bounce_dnew", 32'(digit_new), 32'hD);

    // Key 3 with a bounce on release
    press_key(4'b0001, 4'b0100);
    wait_pulse("pulse_3", 200);
    chk("code_3", 32'(key_code), 32'h3);
    snap = pulses;
    for (int i = 0; i < 4; i++) tick();
    press = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    force_val = 4'b0100;
    force_en  = 1'b1;
    tick();
    force_en = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    chk("rel_bounce_busy", 32'(busy), 32'd1);
    tick();
    chk("rel_bounce_idle", 32'(busy), 32'd0);
    chk("rel_bounce_row", 32'(row), 32'h2);
    chk("rel_bounce_pulses", 32'(pulses - snap), 32'd0);
    chk("dnew_3", 32'(digit_new), 32'h3);
    chk("dold_3", 32'(digit_old), 32'hD);

    // Two columns on one row are ignored
    snap = pulses;
    any_busy = 1'b0;
    press_key(4'b0001, 4'b0011);
    for (int i = 0; i < 40; i++) begin
      tick();
      any_busy = any_busy | busy;
    end
    press = 1'b0;
    chk("two_col_busy", 32'(any_busy), 32'd0);
    chk("two_col_pulse", 32'(pulses - snap), 32'd0);

    // Reset while debouncing key 6
    press_key(4'b0010, 4'b0100);
    wait_busy("enter_debounce", 1'b1, 100);
    tick(); tick(); tick();
    snap = pulses;
    reset = 1'b1;
    press = 1'b0;
    tick();
    chk("mid_rst_row", 32'(row), 32'h1);
    chk("mid_rst_kv", 32'(key_valid), 32'd0);
    chk("mid_rst_code", 32'(key_code), 32'd0);
    chk("mid_rst_dnew", 32'(digit_new), 32'd0);
    chk("mid_rst_dold", 32'(digit_old), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 30; i++) tick();
    chk("mid_rst_no_pulse", 32'(pulses - snap), 32'd0);
    chk("no_consec_kv", 32'(consec), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/keypad_scan_ctrl.md
Name: keypad_scan_ctrl

Overview:
Sequencer for the 4x4 matrix keypad. It drives the one-hot row scan and synchronizes the column inputs. It debounces each press and release, then registers exactly one key event per physical press. A two-digit history (newest/oldest) feeds the dual seven-segment display mux.

Parameters:
SCAN_DIV, 4096, clk cycles each row is driven before advancing (>=4)
DEBOUNCE_CYCLES, 65536, consecutive stable cycles required to accept a press or a release (>=2)

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
col  input  4  raw keypad column sense, active-high, asynchronous to clk
row  output  4  one-hot row drive
key_valid  output  1  one-cycle pulse: new debounced key accepted
key_code  output  4  hex value of last accepted key
digit_new  output  4  most recent key
digit_old  output  4  key before digit_new
busy  output  1  high whenever state != SCAN

Behaviour:
- Reset (sync, active-high, clk edge): state=SCAN, row=4'b0001, dwell/debounce counters=0, key_valid=0, key_code=0, digit_new=0, digit_old=0, busy=0, sync flops=0.
- col passes through a 2-flop synchronizer to give col_s. All decisions use col_s only. This adds 2 cycles of latency.
- Key map, indexed by row and col_s one-hot:
  - row 0001: col 0001=1, 0010=2, 0100=3, 1000=A
  - row 0010: 4, 5, 6, B
  - row 0100: 7, 8, 9, C
  - row 1000: F, 0, E, D
- SCAN:
  - Dwell counter counts 0..SCAN_DIV-1.
  - On the last dwell cycle, col_s is sampled:
    - exactly one bit set: capture col_s into cap, dwell counter=0, go to DEBOUNCE. row stays frozen.
    - zero bits or more than one bit set: row rotates left (1000 wraps to 0001), stay in SCAN.
  - col_s changes before the last dwell cycle are ignored (row settling time).
- DEBOUNCE:
  - Debounce counter starts at 0.
  - Each cycle with col_s==cap: increment.
  - Any cycle with col_s!=cap: counter=0, row advances to the next row, go to SCAN (press rejected).
  - Cycle with counter==DEBOUNCE_CYCLES-1 and col_s==cap: go to HELD. On that edge:
    - key_code <= mapped key
    - digit_old <= digit_new
    - digit_new <= mapped key
    - key_valid <= 1 for exactly one cycle (the first HELD cycle)
  - Press-to-pulse latency: DEBOUNCE_CYCLES cycles after entering DEBOUNCE.
- HELD:
  - row stays frozen.
  - col_s != 0: stay. Extra keys and a changed column are ignored (no rollover, no auto-repeat).
  - col_s == 0: counter=0, go to RELEASE.
- RELEASE:
  - Each cycle with col_s==0: increment.
  - Any nonzero col_s: go back to HELD, counter=0 (bounce on release).
  - Counter reaches DEBOUNCE_CYCLES-1 with col_s==0: row advances to the next row, go to SCAN.
- Boundary conditions:
  - key_valid is never asserted on two consecutive cycles.
  - At most one key_valid per press/release cycle.
  - Reset mid-operation (any state) discards the pending key. The history registers clear.
  - Counters never exceed their terminal count. Widths are $clog2 of each parameter.
  - digit_new and digit_old change only on the key_valid edge.

Test Plan:
(sim: SCAN_DIV=4, DEBOUNCE_CYCLES=8)
- Reset, col=0 -> row cycles 0001,0010,0100,1000,0001, each held 4 cycles. key_valid stays 0, busy=0, digits=0.
- Hold col=0010 steadily while row=0100 is driven -> row frozen at 0100. key_valid pulses once with key_code=8, digit_new=8, digit_old=0. No further pulse while the key is held.
- Press 5, release; then press D, release -> two pulses. Final state digit_new=D, digit_old=5.
- Bouncing press: col toggles 0001/0000 every 3 cycles for 30 cycles on row 0001 -> no key_valid. Scan keeps advancing.
- Bouncing release after accepting key 3: col returns to 0100 once, 5 cycles into RELEASE -> back to HELD. Still exactly one pulse total. Scanning resumes only after 8 clean zero cycles.
- Two columns (0011) active on the sampled row -> ignored, no pulse. Assert reset during DEBOUNCE -> row=0001, outputs zero, no pulse.
